// File: rtl/execute_mul_sequencer_if.sv
// Execute-stage multiply sequencer bus: operands and control in, pipeline
// stall/flush controls and the selected product half out.
interface execute_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             MulStartE;
  logic             MulOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushM;
  logic             BusyE;
  logic             MulDoneE;
  logic [WIDTH-1:0] MulResultE;

  modport master (
    output flush, MulStartE, MulOpE, SrcAE, SrcBE,
    input  StallF, StallD, StallE, FlushM, BusyE, MulDoneE, MulResultE
  );

  modport slave (
    input  flush, MulStartE, MulOpE, SrcAE, SrcBE,
    output StallF, StallD, StallE, FlushM, BusyE, MulDoneE, MulResultE
  );
endinterface

// File: rtl/execute_mul_sequencer.sv
// Multi-cycle shift-add unsigned multiplier controller for the Execute stage.
// Holds F/D/E and bubbles M for WIDTH+1 cycles, then presents the result for one cycle.
module execute_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  execute_mul_sequencer_if.slave mif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand, acc_add;
  logic [WIDTH-1:0]   mplier, result;
  logic [CW-1:0]      cnt;
  logic               op;
  logic               start, stall;

  assign start   = mif.MulStartE & ~mif.flush;
  assign acc_add = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A flush during RUN drops the stalls in the same cycle so the redirected
  // fetch is not held back by a multiply that is being killed.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        stall     = 1'b1;
      end
      RUN: begin
        if (mif.flush) state_nxt = IDLE;
        else begin
          stall = 1'b1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      op     <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= {{WIDTH{1'b0}}, mif.SrcAE};
          mplier <= mif.SrcBE;
          op     <= mif.MulOpE;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: if (!mif.flush) begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Capture the final sum on the last step so DONE presents a registered result.
          if (cnt == LAST) result <= op ? acc_add[2*WIDTH-1:WIDTH] : acc_add[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign mif.StallF     = stall;
  assign mif.StallD     = stall;
  assign mif.StallE     = stall;
  assign mif.FlushM     = stall;
  assign mif.BusyE      = (state == RUN);
  assign mif.MulDoneE   = (state == DONE);
  assign mif.MulResultE = result;
endmodule

// File: tb/tb_execute_mul_sequencer.sv
// Scoreboard bench for execute_mul_sequencer: expected products are queued at
// issue and compared when MulDoneE is seen.
module tb_execute_mul_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  execute_mul_sequencer_if #(.WIDTH(W)) mif ();
  execute_mul_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mif(mif));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] last_res;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return op ? p[2*W-1:W] : p[W-1:0];
  endfunction

  // Runs one multiply from cycle 0 through its DONE cycle; leaves MulStartE high.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        output int done_cyc, output int stall_bad);
    mif.MulStartE = 1'b1;
    mif.MulOpE    = op;
    mif.SrcAE     = a;
    mif.SrcBE     = b;
    exp_q.push_back(model(a, b, op));
    done_cyc  = -1;
    stall_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ({mif.StallF, mif.StallD, mif.StallE, mif.FlushM} !== {4{c <= W}}) stall_bad++;
      if (mif.MulDoneE === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        got_q.push_back(mif.MulResultE);
      end
      @(posedge clk); #1;
      if (c == W + 1) break;
    end
  endtask

  task automatic go_idle();
    mif.MulStartE = 1'b0;
    mif.flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE, mif.MulDoneE, mif.MulResultE} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got stalls=%b%b%b%b busy=%b done=%b res=%h, want all 0",
               mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE, mif.MulDoneE, mif.MulResultE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
  endtask

  task automatic test_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op);
    int dc, sb;
    logic [W-1:0] e, g;
    do_mul(a, b, op, dc, sb);
    go_idle();
    n_vec++;
    if (dc !== W + 1) begin
      n_err++;
      $display("FAIL %s_done_cycle: got %0d, want %0d", name, dc, W + 1);
    end
    n_vec++;
    if (sb !== 0) begin
      n_err++;
      $display("FAIL %s_stalls: %0d cycles wrong, want 0", name, sb);
    end
    n_vec++;
    if (got_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_result: no result observed, want %h", name, model(a, b, op));
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      last_res = g;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s_result: got %h, want %h", name, g, e);
      end
    end
  endtask

  task automatic test_flush();
    int done_seen;
    mif.MulStartE = 1'b1;
    mif.MulOpE    = 1'b0;
    mif.SrcAE     = 7;
    mif.SrcBE     = 9;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    mif.flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE} !== 5'b00001) begin
      n_err++;
      $display("FAIL flush_cycle10: got stalls/busy=%b%b%b%b%b, want 00001",
               mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE);
    end
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    n_vec++;
    if ({mif.StallF, mif.BusyE, mif.MulDoneE} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_idle: got stall=%b busy=%b done=%b, want 000",
               mif.StallF, mif.BusyE, mif.MulDoneE);
    end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mif.MulDoneE === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL flush_no_done: got %0d done cycles, want 0", done_seen);
    end
    n_vec++;
    if (mif.MulResultE !== last_res) begin
      n_err++;
      $display("FAIL flush_result_hold: got %h, want %h", mif.MulResultE, last_res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc1, sb1, dc2, sb2;
    logic [W-1:0] e, g;
    do_mul(2, 3, 1'b0, dc1, sb1);
    do_mul(4, 5, 1'b0, dc2, sb2);
    go_idle();
    n_vec++;
    if (dc1 !== W + 1 || dc2 !== W + 1) begin
      n_err++;
      $display("FAIL b2b_done_cycles: got %0d,%0d, want %0d,%0d", dc1, W + 2 + dc2, W + 1, 2*W + 3);
    end
    n_vec++;
    if (sb1 + sb2 !== 0) begin
      n_err++;
      $display("FAIL b2b_stalls: %0d cycles wrong, want 0", sb1 + sb2);
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q.size() == 0) begin
        n_err++;
        $display("FAIL b2b_result%0d: no result observed", i);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        last_res = g;
        if (g !== e) begin
          n_err++;
          $display("FAIL b2b_result%0d: got %h, want %h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_no_mul();
    int bad;
    bad = 0;
    go_idle();
    for (int c = 0; c < 50; c++) begin
      mif.SrcAE  = $urandom;
      mif.SrcBE  = $urandom;
      mif.MulOpE = $urandom_range(0, 1);
      mif.flush  = $urandom_range(0, 1);
      @(negedge clk);
      if ({mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE, mif.MulDoneE} !== 6'b0) bad++;
      @(posedge clk); #1;
    end
    go_idle();
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL no_mul_quiet: %0d cycles with stall/busy/done set, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    mif.MulStartE = 1'b1;
    mif.MulOpE    = 1'b0;
    mif.SrcAE     = 100;
    mif.SrcBE     = 200;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    go_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mif.StallF, mif.StallD, mif.StallE, mif.FlushM, mif.BusyE, mif.MulDoneE, mif.MulResultE} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got stalls=%b busy=%b done=%b res=%h, want all 0",
               mif.StallF, mif.BusyE, mif.MulDoneE, mif.MulResultE);
    end
    last_res = '0;
    @(posedge clk); #1;
    test_mul("after_reset", 32'd12345, 32'd678, 1'b0);
    test_mul("after_reset_hi", 32'h89AB_CDEF, 32'h1234_5678, 1'b1);
  endtask

  initial begin
    mif.flush     = 1'b0;
    mif.MulStartE = 1'b0;
    mif.MulOpE    = 1'b0;
    mif.SrcAE     = '0;
    mif.SrcBE     = '0;
    test_reset();
    test_mul("basic", 32'd3, 32'd5, 1'b0);
    test_mul("mulhu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    test_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    test_mul("zero", 32'd0, 32'hDEAD_BEEF, 1'b0);
    test_mul("identity", 32'd1, 32'hDEAD_BEEF, 1'b0);
    test_flush();
    test_back_to_back();
    test_no_mul();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
